pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central hazard controller for the 5-stage pipeline: drives enable/flush of IF_ID and ID_EXE regs and PC enable.
//  Computes per-operand forward selects in ID (registered downstream through ID_EXE) and detects load-use stalls.
//  Sequences branch/jump flushes from EX and an ecall-halt drain FSM; optional perf counters.
// PARAMETERS
//  DRAIN_CYCLES  2   cycles after halt request before freeze (lets MEM/WB retire)
//  CNT_W         32  width of perf counters
// PORTS
//  clk            in   1  system clock, rising edge
//  rst            in   1  synchronous reset, active-high
//  id_rs1         in   5  rs1 of instr in ID
//  id_rs2         in   5  rs2 of instr in ID
//  id_rs1_used    in   1  ID instr reads rs1
//  id_rs2_used    in   1  ID instr reads rs2
//  ex_rd          in   5  rd of instr in EX
//  ex_reg_write   in   1  EX instr writes rd
//  ex_mem_to_reg  in   1  EX instr is a load
//  mem_rd         in   5  rd of instr in MEM
//  mem_reg_write  in   1  MEM instr writes rd
//  ex_redirect    in   1  EX branch taken / jal / jalr
//  ex_halt        in   1  EX ecall resolved as halt
//  pc_en          out  1  PC update enable
//  if_id_en       out  1  IF_ID enable
//  if_id_flush    out  1  IF_ID flush
//  id_ex_en       out  1  ID_EXE enable
//  id_ex_flush    out  1  ID_EXE flush (inserts bubble)
//  r1_forward     out  2  rs1 forward select for ID_EXE
//  r2_forward     out  2  rs2 forward select for ID_EXE
//  halted         out  1  FSM in HALT
//  stall_cnt      out  CNT_W  load-use stall cycles (perf)
//  flush_cnt      out  CNT_W  redirect flush events (perf)
// BEHAVIOUR
//  - FSM states RUN, DRAIN, HALT; state/counters registered, all outputs combinational from state+inputs.
//  - rst: next edge state=RUN, drain_cnt=0, perf counters=0; while rst high: pc_en=if_id_en=id_ex_en=1, both flushes=1, fwd=00, halted=0.
//  - Forward (per operand, RUN only): rs==0 or !used -> 00; rs==ex_rd & ex_reg_write -> 01 (EX/MEM);
//    else rs==mem_rd & mem_reg_write -> 10 (MEM/WB); else 00. EX match beats MEM match. 11 never driven.
//  - Load-use: ex_mem_to_reg & ex_reg_write & ex_rd!=0 & matches a used rs -> pc_en=0, if_id_en=0, id_ex_flush=1, for exactly one cycle;
//    after the bubble the load sits in MEM and normal forwarding yields 10.
//  - Redirect: ex_redirect -> if_id_flush=1, id_ex_flush=1, pc_en=1; overrides load-use (no stall that cycle).
//  - Priority: rst > ex_halt > ex_redirect > load-use > normal.
//  - ex_halt in RUN: that cycle pc_en=0, if_id_flush=1, id_ex_flush=1; next state DRAIN, drain_cnt=0.
//  - DRAIN: pc_en=0, flushes=1, enables=1; drain_cnt++ each cycle; at drain_cnt==DRAIN_CYCLES-1 -> HALT.
//  - HALT: pc_en=if_id_en=id_ex_en=0, flushes=0, halted=1; leaves only via rst. ex_halt/ex_redirect ignored outside RUN.
//  - Reset mid-DRAIN/HALT returns to RUN at next edge.
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined: stall_cnt += 1 per load-use stall cycle, flush_cnt += 1 per ex_redirect accepted in RUN; wrap at 2^CNT_W.
//  Undefined: no counter flops; stall_cnt/flush_cnt tied to 0.
// STRUCTURE
//  Shared header pipe_ctrl_defs.vh: FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10, state codes ST_RUN/ST_DRAIN/ST_HALT.
//  Sub-module fwd_select (combinational, one instance per operand): rs, used, ex/mem rd+we -> 2-bit select.
// TESTING
//  1. add x5 in EX, ID reads rs1=x5 used -> r1_forward=01, no stall; same with x5 only in MEM -> 10.
//  2. lw x6 in EX, ID rs2=x6 used -> 1 cycle pc_en=0,if_id_en=0,id_ex_flush=1; next cycle r2_forward=10, enables=1.
//  3. lw x0 in EX, ID rs1=x0 -> no stall, r1_forward=00.
//  4. ex_redirect=1 together with load-use hazard -> if_id_flush=id_ex_flush=1, pc_en=1, stall_cnt unchanged, flush_cnt+1.
//  5. ex_halt=1 at cycle t -> DRAIN t+1..t+2, halted=1 from t+3, all enables 0; rst at t+5 -> RUN, outputs per reset rule.
//  6. rst asserted during DRAIN -> state RUN next edge, counters 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forward-select codes,
// control FSM state encoding and register-index width.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned REG_W = 5;

  // Operand source selects carried through ID_EXE into the EX operand muxes
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_DRAIN = 2'b01,
    ST_HALT  = 2'b10
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Per-operand forward selector: picks the youngest in-flight producer of rs.
// x0 and unread operands always come from the register file.
module fwd_select
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] i_rs,
  input  logic             i_used,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_ex_we,
  input  logic [REG_W-1:0] i_mem_rd,
  input  logic             i_mem_we,
  output logic [1:0]       o_sel_c
);

  // EX result is younger than MEM result, so it wins on a double match
  always_comb begin
    o_sel_c = FWD_RF;
    if (i_used && (i_rs != REG_W'(0))) begin
      if (i_ex_we && (i_rs == i_ex_rd)) begin
        o_sel_c = FWD_EXMEM;
      end else if (i_mem_we && (i_rs == i_mem_rd)) begin
        o_sel_c = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for the 5-stage pipeline: forwarding selects,
// load-use stall, redirect flush and ecall-halt drain sequencing.
// Optional perf counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_to_reg,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic             ex_redirect,
  input  logic             ex_halt,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic [1:0]       r1_forward,
  output logic [1:0]       r2_forward,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic [DRAIN_W-1:0] w_drain_nxt;
  logic [1:0]         w_r1_sel;
  logic [1:0]         w_r2_sel;
  logic               w_load_use;
  logic               w_stall_inc;
  logic               w_flush_inc;

  fwd_select u_fwd_rs1 (
    .i_rs     (id_rs1),
    .i_used   (id_rs1_used),
    .i_ex_rd  (ex_rd),
    .i_ex_we  (ex_reg_write),
    .i_mem_rd (mem_rd),
    .i_mem_we (mem_reg_write),
    .o_sel_c  (w_r1_sel)
  );

  fwd_select u_fwd_rs2 (
    .i_rs     (id_rs2),
    .i_used   (id_rs2_used),
    .i_ex_rd  (ex_rd),
    .i_ex_we  (ex_reg_write),
    .i_mem_rd (mem_rd),
    .i_mem_we (mem_reg_write),
    .o_sel_c  (w_r2_sel)
  );

  // A load in EX cannot forward to ID in time; one bubble lets it reach MEM
  assign w_load_use = ex_mem_to_reg && ex_reg_write && (ex_rd != 5'd0) &&
                      ((id_rs1_used && (id_rs1 == ex_rd)) ||
                       (id_rs2_used && (id_rs2 == ex_rd)));

  // State and drain counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_nxt;
    end
  end

  // Next state and pipeline controls; priority rst > halt > redirect > load-use
  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain_cnt;
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    r1_forward  = FWD_RF;
    r2_forward  = FWD_RF;
    halted      = 1'b0;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;
    if (rst) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      w_state_nxt = ST_RUN;
      w_drain_nxt = '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r1_forward = w_r1_sel;
          r2_forward = w_r2_sel;
          if (ex_halt) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            w_state_nxt = ST_DRAIN;
            w_drain_nxt = '0;
          end else if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            w_flush_inc = 1'b1;
          end else if (w_load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            w_stall_inc = 1'b1;
          end
        end
        ST_DRAIN: begin
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          w_drain_nxt = r_drain_cnt + DRAIN_W'(1);
          if (r_drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
            w_state_nxt = ST_HALT;
          end
        end
        ST_HALT: begin
          pc_en    = 1'b0;
          if_id_en = 1'b0;
          id_ex_en = 1'b0;
          halted   = 1'b1;
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Perf counters: stall cycles and accepted redirects, free-running wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_inc) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  logic w_unused;
  assign w_unused  = &{1'b0, w_stall_inc, w_flush_inc};
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (default parameters).
// Counter expectations follow PIPE_PERF_CNT_EN: tracked when defined, zero otherwise.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd;
  logic        id_rs1_used, id_rs2_used, ex_reg_write, ex_mem_to_reg;
  logic        mem_reg_write, ex_redirect, ex_halt;
  logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, halted;
  logic [1:0]  r1_forward, r2_forward;
  logic [31:0] stall_cnt, flush_cnt;
  logic [5:0]  ctl;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_stall = 0;
  logic [31:0] exp_flush = 0;

  // ctl bit order: pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, halted
  localparam logic [5:0] C_RESET = 6'b111110;
  localparam logic [5:0] C_NORM  = 6'b111000;
  localparam logic [5:0] C_STALL = 6'b001010;
  localparam logic [5:0] C_REDIR = 6'b111110;
  localparam logic [5:0] C_DRAIN = 6'b011110;
  localparam logic [5:0] C_HALT  = 6'b000001;

  assign ctl = {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, halted};

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .ex_redirect(ex_redirect), .ex_halt(ex_halt),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
    .r1_forward(r1_forward), .r2_forward(r2_forward), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic logic [31:0] cnt_exp(input logic [31:0] v);
`ifdef PIPE_PERF_CNT_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  task automatic set_in(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                        input logic [4:0] erd, input logic ewe, input logic eld,
                        input logic [4:0] mrd, input logic mwe, input logic redir, input logic hlt);
    id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    ex_rd = erd; ex_reg_write = ewe; ex_mem_to_reg = eld;
    mem_rd = mrd; mem_reg_write = mwe; ex_redirect = redir; ex_halt = hlt;
    #2;
  endtask

  task automatic idle();
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (ctl !== C_RESET) begin n_errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_RESET); end
    n_checks++;
    if ({r1_forward, r2_forward} !== 4'b0000) begin
      n_errors++; $display("FAIL reset_fwd got=%b%b exp=0000", r1_forward, r2_forward);
    end
    tick(); tick();
    rst = 1'b0;
    idle();
    n_checks++;
    if (ctl !== C_NORM) begin n_errors++; $display("FAIL post_reset_ctl got=%b exp=%b", ctl, C_NORM); end
    n_checks++;
    if ({stall_cnt, flush_cnt} !== 64'd0) begin
      n_errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_forward();
    // x5 in EX, read by rs1
    set_in(5'd5, 1'b1, 5'd7, 1'b1, 5'd5, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if ({r1_forward, r2_forward, ctl} !== {2'b01, 2'b00, C_NORM}) begin
      n_errors++; $display("FAIL fwd_ex got=%b %b %b exp=01 00 %b", r1_forward, r2_forward, ctl, C_NORM);
    end
    // x5 only in MEM
    set_in(5'd5, 1'b1, 5'd7, 1'b1, 5'd3, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if ({r1_forward, r2_forward} !== 4'b1000) begin
      n_errors++; $display("FAIL fwd_mem got=%b%b exp=1000", r1_forward, r2_forward);
    end
    // both stages write x9: EX wins, on rs2
    set_in(5'd1, 1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if ({r1_forward, r2_forward} !== 4'b0001) begin
      n_errors++; $display("FAIL fwd_prio got=%b%b exp=0001", r1_forward, r2_forward);
    end
    // match but operand not read, and match but EX not writing
    set_in(5'd9, 1'b0, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if ({r1_forward, r2_forward} !== 4'b0000) begin
      n_errors++; $display("FAIL fwd_unused got=%b%b exp=0000", r1_forward, r2_forward);
    end
    // x0 never forwarded
    set_in(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if ({r1_forward, r2_forward} !== 4'b0000) begin
      n_errors++; $display("FAIL fwd_x0 got=%b%b exp=0000", r1_forward, r2_forward);
    end
  endtask

  task automatic test_load_use();
    // lw x6 in EX, rs2=x6 used
    set_in(5'd1, 1'b1, 5'd6, 1'b1, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ctl !== C_STALL) begin n_errors++; $display("FAIL lu_stall got=%b exp=%b", ctl, C_STALL); end
    tick();
    exp_stall = exp_stall + 1;
    // bubble now in EX, load in MEM
    set_in(5'd1, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if ({ctl, r2_forward} !== {C_NORM, 2'b10}) begin
      n_errors++; $display("FAIL lu_after got=%b %b exp=%b 10", ctl, r2_forward, C_NORM);
    end
    n_checks++;
    if (stall_cnt !== cnt_exp(exp_stall)) begin
      n_errors++; $display("FAIL lu_cnt got=%0d exp=%0d", stall_cnt, cnt_exp(exp_stall));
    end
    // lw x6 with x6 present only on an unused operand
    set_in(5'd6, 1'b0, 5'd2, 1'b1, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ctl !== C_NORM) begin n_errors++; $display("FAIL lu_unused got=%b exp=%b", ctl, C_NORM); end
    // lw x0, rs1=x0
    set_in(5'd0, 1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({ctl, r1_forward} !== {C_NORM, 2'b00}) begin
      n_errors++; $display("FAIL lu_x0 got=%b %b exp=%b 00", ctl, r1_forward, C_NORM);
    end
    tick();
  endtask

  task automatic test_redirect();
    // redirect with a simultaneous load-use hazard on rs1
    set_in(5'd8, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (ctl !== C_REDIR) begin n_errors++; $display("FAIL redir_ctl got=%b exp=%b", ctl, C_REDIR); end
    tick();
    exp_flush = exp_flush + 1;
    // back-to-back redirect
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    tick();
    exp_flush = exp_flush + 1;
    idle();
    n_checks++;
    if ({stall_cnt, flush_cnt} !== {cnt_exp(exp_stall), cnt_exp(exp_flush)}) begin
      n_errors++; $display("FAIL redir_cnt got=%0d/%0d exp=%0d/%0d",
                           stall_cnt, flush_cnt, cnt_exp(exp_stall), cnt_exp(exp_flush));
    end
  endtask

  task automatic test_halt();
    // cycle t: halt beats a simultaneous redirect
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (ctl !== C_DRAIN) begin n_errors++; $display("FAIL halt_t got=%b exp=%b", ctl, C_DRAIN); end
    tick();
    // t+1, t+2: drain, with redirect/load-use/forward inputs that must be ignored
    for (int c = 1; c <= 2; c++) begin
      set_in(5'd4, 1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1);
      n_checks++;
      if ({ctl, r1_forward, r2_forward} !== {C_DRAIN, 4'b0000}) begin
        n_errors++; $display("FAIL drain_t%0d got=%b %b%b exp=%b 0000", c, ctl, r1_forward, r2_forward, C_DRAIN);
      end
      tick();
    end
    // t+3, t+4: halted
    for (int c = 3; c <= 4; c++) begin
      n_checks++;
      if (ctl !== C_HALT) begin n_errors++; $display("FAIL halt_t%0d got=%b exp=%b", c, ctl, C_HALT); end
      tick();
    end
    n_checks++;
    if ({stall_cnt, flush_cnt} !== {cnt_exp(exp_stall), cnt_exp(exp_flush)}) begin
      n_errors++; $display("FAIL halt_cnt got=%0d/%0d exp=%0d/%0d",
                           stall_cnt, flush_cnt, cnt_exp(exp_stall), cnt_exp(exp_flush));
    end
    // t+5: reset out of HALT
    rst = 1'b1;
    idle();
    n_checks++;
    if (ctl !== C_RESET) begin n_errors++; $display("FAIL halt_rst got=%b exp=%b", ctl, C_RESET); end
    tick();
    rst = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
    idle();
    n_checks++;
    if (ctl !== C_NORM) begin n_errors++; $display("FAIL halt_rst_run got=%b exp=%b", ctl, C_NORM); end
  endtask

  task automatic test_reset_in_drain();
    // build nonzero counters first so the clear is observable
    set_in(5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    tick();
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    n_checks++;
    if ({ctl, stall_cnt, flush_cnt} !== {C_DRAIN, cnt_exp(32'd1), cnt_exp(32'd1)}) begin
      n_errors++; $display("FAIL rd_pre got=%b %0d/%0d exp=%b %0d/%0d",
                           ctl, stall_cnt, flush_cnt, C_DRAIN, cnt_exp(32'd1), cnt_exp(32'd1));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    n_checks++;
    if ({ctl, stall_cnt, flush_cnt} !== {C_NORM, 64'd0}) begin
      n_errors++; $display("FAIL rd_post got=%b %0d/%0d exp=%b 0/0", ctl, stall_cnt, flush_cnt, C_NORM);
    end
    // stays in RUN: a further cycle still normal
    tick();
    n_checks++;
    if (ctl !== C_NORM) begin n_errors++; $display("FAIL rd_run got=%b exp=%b", ctl, C_NORM); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_redirect();
    test_halt();
    test_reset_in_drain();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
